uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue_if.sv | 19 +
 rtl/uart_tx_queue.sv | 156 +++++++++++++++
 tb/tb_uart_tx_queue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// Byte-write handshake between a CPU-side producer and the UART transmit queue.
// The producer drives the strobe and byte; the queue answers with ready.
interface uart_tx_queue_if;
  logic       uartWriteReq;
  logic [7:0] uartWriteData;
  logic       uartWriteReady;

  modport master (
    output uartWriteReq,
    output uartWriteData,
    input  uartWriteReady
  );

  modport slave (
    input  uartWriteReq,
    input  uartWriteData,
    output uartWriteReady
  );
endinterface

// File: rtl/uart_tx_queue.sv
// UART transmitter fed by a 2^DEPTH_LOG2-byte FIFO; 8N1 framing by default,
// 8E1 (even parity bit between data and stop) when UART_TX_PARITY_EN is defined.
module uart_tx_queue #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 3
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_queue_if.slave      wr,
  output logic                txd,
  output logic                txBusy,
  output logic [DEPTH_LOG2:0] fifoCount
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [15:0]       BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  txd_d;
  logic                  pop;
  logic                  push;
  logic                  armed_q;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic [7:0]            mem [DEPTH];
  logic                  bit_end;

  assign wr.uartWriteReady = (count_q < FULL);
  assign fifoCount         = count_q;
  assign txBusy            = (state_q != S_IDLE) || (count_q != '0);

  // armed_q stays low through the first edge after reset release so that
  // edge never accepts a byte.
  assign push = wr.uartWriteReq & wr.uartWriteReady & armed_q;

  // NOTE: FIFO storage has no reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.uartWriteData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd     <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd     <= txd_d;
    end
  end

  assign bit_end = (baud_q == BAUD_LAST);

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? 16'd0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = 1'b1;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr];
          bit_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        txd_d = shreg_q[bit_q];
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        txd_d = ^shreg_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          // Back-to-back frames: a queued byte skips IDLE entirely.
          if (count_q != '0) begin
            pop     = 1'b1;
            shreg_d = mem[rd_ptr];
            bit_d   = 3'd0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: random writes against a timing-level
// model of the queue (accept/pop edges, frame start times) plus a serial decoder.
module tb_uart_tx_queue;

  localparam int CPB   = 4;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          txd;
  logic          txBusy;
  logic [DL:0]   fifoCount;

  uart_tx_queue_if wr_bus ();

  uart_tx_queue #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr_bus),
    .txd       (txd),
    .txBusy    (txBusy),
    .fifoCount (fifoCount)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         edge_n = 0;
  int         preds[$];        // predicted txd-fall edge of each accepted byte
  logic [7:0] bytes[$];        // accepted bytes in enqueue order
  int         mon_idx = 0;
  bit         armed_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // A byte is popped on the edge before its frame's txd falls.
  function automatic int model_count();
    int popped = 0;
    foreach (preds[k]) if (preds[k] - 1 <= edge_n) popped++;
    return preds.size() - popped;
  endfunction

  function automatic bit model_busy();
    if (model_count() > 0) return 1'b1;
    foreach (preds[k])
      if (preds[k] - 1 <= edge_n && edge_n < preds[k] - 1 + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic cycle(input bit req, input logic [7:0] d);
    bit acc;
    int cnt;
    int p;
    wr_bus.uartWriteReq  = req;
    wr_bus.uartWriteData = d;
    @(negedge clk);
    cnt = model_count();
    check("fifoCount", 32'(fifoCount), 32'(cnt));
    check("ready", 32'(wr_bus.uartWriteReady), 32'(cnt < DEPTH));
    check("txBusy", 32'(txBusy), 32'(model_busy()));
    acc = req && (cnt < DEPTH) && armed_model;
    @(posedge clk);
    edge_n++;
    armed_model = 1'b1;
    if (acc) begin
      p = edge_n + 2;
      if (preds.size() > 0 && preds[$] + FRAME > p) p = preds[$] + FRAME;
      preds.push_back(p);
      bytes.push_back(d);
    end
    #1;
  endtask

  task automatic drain();
    int limit;
    limit = (preds.size() - mon_idx + 1) * FRAME + 50;
    for (int i = 0; i < limit && mon_idx < preds.size(); i++) cycle(1'b0, 8'h00);
    check("drained_frames", 32'(mon_idx), 32'(preds.size()));
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b0;
    wr_bus.uartWriteReq = 1'b0;
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_fifoCount", 32'(fifoCount), 32'd0);
    check("rst_ready", 32'(wr_bus.uartWriteReady), 32'd1);
    check("rst_txBusy", 32'(txBusy), 32'd0);
    preds.delete();
    bytes.delete();
    mon_idx = 0;
    armed_model = 1'b0;
    tick();
    tick();
    #1;
    reset = 1'b1;
  endtask

  // Serial decoder: each bit must hold for exactly CPB cycles.
  int          mon_k;
  int          mon_s;
  bit          mon_expected;
  bit          mon_abort;
  logic [7:0]  mon_d;
  logic [NBITS-1:0] mon_ev;
  logic [31:0] mon_obs;

  always begin
    @(negedge clk);
    if (reset === 1'b1 && txd === 1'b0) begin
      mon_k        = mon_idx;
      mon_s        = edge_n;
      mon_abort    = 1'b0;
      mon_expected = (mon_k < preds.size());
      if (mon_expected) begin
        mon_d = bytes[mon_k];
        check($sformatf("frame%0d_start_edge", mon_k), 32'(mon_s), 32'(preds[mon_k]));
      end else begin
        mon_d = 8'h00;
        check("unexpected_frame_txd", 32'(txd), 32'd1);
      end
`ifdef UART_TX_PARITY_EN
      mon_ev = {1'b1, ^mon_d, mon_d, 1'b0};
`else
      mon_ev = {1'b1, mon_d, 1'b0};
`endif
      for (int b = 0; b < NBITS; b++) begin
        mon_obs = '0;
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (reset !== 1'b1) mon_abort = 1'b1;
          if (mon_abort) break;
          mon_obs = {mon_obs[30:0], txd};
        end
        if (mon_abort) break;
        if (mon_expected)
          check($sformatf("frame%0d_bit%0d", mon_k, b), mon_obs,
                mon_ev[b] ? 32'((1 << CPB) - 1) : 32'd0);
      end
      if (!mon_abort && mon_expected) mon_idx++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    wr_bus.uartWriteReq  = 1'b0;
    wr_bus.uartWriteData = 8'h00;
    tick();
    do_reset();

    // Single byte 0xA5: latency, bit order, busy duration.
    cycle(1'b1, 8'hA5);
    drain();

    // Nine consecutive writes: fills to 8 with first byte already popped.
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(i));
    drain();

    // Request held high while full: simultaneous push/pop and dropped bytes.
    for (int i = 0; i < 200; i++) cycle(1'b1, 8'($urandom));
    drain();

    // Reset in the middle of data bit 3 with five bytes still queued.
    a0 = edge_n + 1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom));
    while (edge_n < a0 + 2 + 4 * CPB + 1) cycle(1'b0, 8'h00);
    check("pre_reset_fifoCount", 32'(fifoCount), 32'd5);
    do_reset();
    cycle(1'b1, 8'h3C);   // first edge after release: must be ignored
    cycle(1'b1, 8'h3C);
    drain();
    check("post_reset_frames", 32'(mon_idx), 32'd1);

    // Parity-relevant bytes (plain frames when parity is disabled).
    cycle(1'b1, 8'h07);
    drain();
    cycle(1'b1, 8'h03);
    drain();

    // Twenty bytes at varied gaps, wrapping the pointers twice.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'($urandom));
      repeat ($urandom_range(0, 50)) cycle(1'b0, 8'h00);
    end
    drain();

    // Random request pattern.
    for (int i = 0; i < 300; i++) cycle(1'($urandom), 8'($urandom));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
